// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one I2C master between
// NUM_REQ requesters; returns status and read data with a one-cycle done pulse.
module i2c_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TO_W    = 12,
    parameter int TIMEOUT = 4000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [1:0]             status,
    output logic [7:0]             rdata,
    output logic                   m_enable,
    output logic [6:0]             m_address,
    output logic                   m_rw,
    output logic [7:0]             m_wdata,
    input  logic                   m_busy,
    input  logic                   m_nack,
    input  logic [7:0]             m_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_RUN      = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [TO_W-1:0]    timer;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   winner;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic [6:0]         sel_addr;
    logic               sel_rw;
    logic [7:0]         sel_wdata;
    logic               limit_hit;

    assign limit_hit = (timer == TO_W'(TIMEOUT - 1));

    // Rotating priority search starting just after the previous winner.
    // NOTE: every variable assigned in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[7*i +: 7];
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (arb_found)               state_next = S_LAUNCH;
            S_LAUNCH:   if (m_busy)                  state_next = S_RUN;
                        else if (limit_hit)          state_next = S_COMPLETE;
            S_RUN:      if (!m_busy || limit_hit)    state_next = S_COMPLETE;
            S_COMPLETE:                              state_next = S_IDLE;
            default:                                 state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt        <= '0;
            status     <= ST_OK;
            rdata      <= '0;
            m_enable   <= 1'b0;
            m_address  <= '0;
            m_rw       <= 1'b0;
            m_wdata    <= '0;
            timer      <= '0;
            winner     <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        gnt       <= NUM_REQ'(1) << arb_idx;
                        winner    <= arb_idx;
                        m_address <= sel_addr;
                        m_rw      <= sel_rw;
                        m_wdata   <= sel_wdata;
                        m_enable  <= 1'b1;
                        timer     <= '0;
                    end
                end
                S_LAUNCH: begin
                    if (m_busy) begin
                        m_enable <= 1'b0;
                        timer    <= '0;
                    end else if (limit_hit) begin
                        m_enable <= 1'b0;
                        status   <= ST_TIMEOUT;
                        rdata    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RUN: begin
                    // Completion wins over the limit when both land on one cycle.
                    if (!m_busy) begin
                        status <= {1'b0, m_nack};
                        rdata  <= (m_rw && !m_nack) ? m_rdata : 8'h00;
                    end else if (limit_hit) begin
                        status <= ST_TIMEOUT;
                        rdata  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_COMPLETE: begin
                    last_grant <= winner;
                    gnt        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign done = (state == S_COMPLETE) ? gnt : '0;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: write, read, round-robin order, nack,
// launch/run timeouts, completion-at-limit and asynchronous reset mid-transaction.
module tb_i2c_master_arbiter;

    localparam int NUM_REQ = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_rw;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [1:0]           status;
    logic [7:0]           rdata;
    logic                 m_enable;
    logic [6:0]           m_address;
    logic                 m_rw;
    logic [7:0]           m_wdata;
    logic                 m_busy;
    logic                 m_nack;
    logic [7:0]           m_rdata;

    int total = 0;
    int bad   = 0;

    i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .TO_W(12), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .status    (status),
        .rdata     (rdata),
        .m_enable  (m_enable),
        .m_address (m_address),
        .m_rw      (m_rw),
        .m_wdata   (m_wdata),
        .m_busy    (m_busy),
        .m_nack    (m_nack),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master model: busy seen for busy_cycles edges, then drops with nack/rdata.
    task automatic run_txn(input int busy_cycles, input logic nack, input logic [7:0] rd);
        m_busy = 1'b1;
        tick(1);
        check("m_enable_drop", 32'(m_enable), 32'd0);
        if (busy_cycles > 1) tick(busy_cycles - 1);
        m_busy  = 1'b0;
        m_nack  = nack;
        m_rdata = rd;
        tick(1);
        m_nack  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        rst = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
        m_busy = 1'b0; m_nack = 1'b0; m_rdata = '0;
        tick(2);
        check("rst_gnt",      32'(gnt),       32'h0);
        check("rst_done",     32'(done),      32'h0);
        check("rst_status",   32'(status),    32'h0);
        check("rst_rdata",    32'(rdata),     32'h0);
        check("rst_m_enable", 32'(m_enable),  32'h0);
        check("rst_m_addr",   32'(m_address), 32'h0);
        rst = 1'b1;
        tick(1);

        // Single write from requester 0
        req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_wdata[7:0] = 8'hA5; req = 4'b0001;
        tick(1);
        check("wr_gnt",      32'(gnt),       32'h1);
        check("wr_m_enable", 32'(m_enable),  32'h1);
        check("wr_m_addr",   32'(m_address), 32'h50);
        check("wr_m_wdata",  32'(m_wdata),   32'hA5);
        check("wr_m_rw",     32'(m_rw),      32'h0);
        run_txn(20, 1'b0, 8'h00);
        check("wr_done",   32'(done),   32'h1);
        check("wr_status", 32'(status), 32'h0);
        check("wr_rdata",  32'(rdata),  32'h0);
        req = '0;
        tick(1);
        check("wr_gnt_clr",  32'(gnt),  32'h0);
        check("wr_done_clr", 32'(done), 32'h0);

        // Read from requester 2
        req_addr[20:14] = 7'h2A; req_rw[2] = 1'b1; req = 4'b0100;
        tick(1);
        check("rd_gnt",      32'(gnt),       32'h4);
        check("rd_m_rw",     32'(m_rw),      32'h1);
        check("rd_m_addr",   32'(m_address), 32'h2A);
        check("rd_m_enable", 32'(m_enable),  32'h1);
        run_txn(5, 1'b0, 8'h3C);
        check("rd_done",   32'(done),   32'h4);
        check("rd_status", 32'(status), 32'h0);
        check("rd_rdata",  32'(rdata),  32'h3C);
        req = '0;
        tick(1);

        // Round-robin with all requesters held, from reset priority
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_addr[7*i +: 7] = 7'h10 + 7'(i);
        req_rw = '0;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            check("rr_gnt",  32'(gnt),       32'(4'b0001 << exp_order[t]));
            check("rr_addr", 32'(m_address), 32'(7'h10 + 7'(exp_order[t])));
            run_txn(2, 1'b0, 8'h00);
            check("rr_done", 32'(done),      32'(4'b0001 << exp_order[t]));
            tick(1);
        end
        req = '0;
        tick(1);

        // NACK on a read returns status 01 and zero data
        req_rw[1] = 1'b1; req = 4'b0010;
        tick(1);
        check("nack_gnt", 32'(gnt), 32'h2);
        run_txn(4, 1'b1, 8'hFF);
        check("nack_done",   32'(done),   32'h2);
        check("nack_status", 32'(status), 32'h1);
        check("nack_rdata",  32'(rdata),  32'h0);
        req = '0;
        tick(1);

        // Launch timeout: master never raises busy
        req_rw[3] = 1'b0; req = 4'b1000;
        tick(1);
        check("lto_gnt", 32'(gnt), 32'h8);
        cnt = 0;
        while (m_enable && cnt < 40) begin
            cnt++;
            tick(1);
        end
        check("lto_enable_cycles", 32'(cnt),    32'd16);
        check("lto_done",          32'(done),   32'h8);
        check("lto_status",        32'(status), 32'h2);
        req = '0;
        tick(1);

        // Busy drops exactly on the limit cycle: completion, not timeout
        req_rw[0] = 1'b1; req = 4'b0001;
        tick(1);
        check("lim_gnt", 32'(gnt), 32'h1);
        m_busy = 1'b1;
        tick(16);
        m_busy = 1'b0; m_rdata = 8'h77;
        tick(1);
        check("lim_done",   32'(done),   32'h1);
        check("lim_status", 32'(status), 32'h0);
        check("lim_rdata",  32'(rdata),  32'h77);
        req = '0;
        tick(1);

        // Run timeout: busy stuck high
        req = 4'b0001;
        tick(1);
        m_busy = 1'b1;
        tick(1);
        m_rdata = 8'hEE;
        cnt = 0;
        while (done == '0 && cnt < 40) begin
            tick(1);
            cnt++;
        end
        check("rto_run_cycles", 32'(cnt),    32'd16);
        check("rto_done",       32'(done),   32'h1);
        check("rto_status",     32'(status), 32'h2);
        check("rto_rdata",      32'(rdata),  32'h0);
        m_busy = 1'b0; req = '0;
        tick(1);
        check("rto_status_hold", 32'(status), 32'h2);

        // Asynchronous reset while requester 1 is in RUN
        req = 4'b0010;
        tick(1);
        m_busy = 1'b1;
        tick(1);
        check("rst_mid_gnt_before", 32'(gnt), 32'h2);
        rst = 1'b0;
        #1;
        check("rst_mid_gnt",      32'(gnt),      32'h0);
        check("rst_mid_m_enable", 32'(m_enable), 32'h0);
        check("rst_mid_done",     32'(done),     32'h0);
        m_busy = 1'b0; req = 4'b0011;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("post_rst_gnt", 32'(gnt), 32'h1);
        run_txn(2, 1'b0, 8'h00);
        check("post_rst_done", 32'(done), 32'h1);
        req = '0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
